// File: rtl/de10_pkg.sv
// Shared definitions for DE10-Standard push-button and seven-segment blocks.
// Holds the BCD digit type, key polarity and the default debounce length.
package de10_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic       KEY_PRESSED   = 1'b0;
    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t BCD_MIN_DIGIT = 4'd0;

    // 20 ms at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam int NUM_KEYS  = 3;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_CLEAR = 2;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and level debouncer for one active-low push-button.
// Emits a one-cycle press pulse one edge after the stable level falls.
module key_debounce
    import de10_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        // Count only uninterrupted disagreement; the final step flips the level.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = (stable_prev_q != KEY_PRESSED) && (stable_q == KEY_PRESSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= key_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
            press_q       <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/bcd_key_counter.sv
// Two-digit BCD up/down counter stepped by debounced key presses.
// Clear dominates; simultaneous up and down cancel; wrap pulses on 99<->00.
module bcd_key_counter
    import de10_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_clear,
    output logic [7:0] bcd_out,
    output logic       wrap
);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] press;

    assign key_raw[KEY_UP]    = key_up;
    assign key_raw[KEY_DOWN]  = key_down;
    assign key_raw[KEY_CLEAR] = key_clear;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .key_raw (key_raw[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    bcd_digit_t tens_q;
    bcd_digit_t tens_d;
    bcd_digit_t ones_q;
    bcd_digit_t ones_d;
    logic       wrap_q;
    logic       wrap_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        wrap_d = 1'b0;
        if (press[KEY_CLEAR]) begin
            tens_d = BCD_MIN_DIGIT;
            ones_d = BCD_MIN_DIGIT;
        end else if (press[KEY_UP] && !press[KEY_DOWN]) begin
            if (ones_q == BCD_MAX_DIGIT) begin
                ones_d = BCD_MIN_DIGIT;
                if (tens_q == BCD_MAX_DIGIT) begin
                    tens_d = BCD_MIN_DIGIT;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (press[KEY_DOWN] && !press[KEY_UP]) begin
            if (ones_q == BCD_MIN_DIGIT) begin
                ones_d = BCD_MAX_DIGIT;
                if (tens_q == BCD_MIN_DIGIT) begin
                    tens_d = BCD_MAX_DIGIT;
                    wrap_d = 1'b1;
                end else begin
                    tens_d = tens_q - 4'd1;
                end
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= BCD_MIN_DIGIT;
            ones_q <= BCD_MIN_DIGIT;
            wrap_q <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            wrap_q <= wrap_d;
        end
    end

    assign bcd_out = {tens_q, ones_q};
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_key_counter.sv
// Self-checking bench for bcd_key_counter with a short debounce window.
// Expected values come from an integer 0..99 model and hand-written tables.
module tb_bcd_key_counter;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_up = 1'b1;
    logic       key_down = 1'b1;
    logic       key_clear = 1'b1;
    logic [7:0] bcd_out;
    logic       wrap;

    int total = 0;
    int bad = 0;
    int model_val = 0;

    bcd_key_counter #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_clear (key_clear),
        .bcd_out   (bcd_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    up;
        bit    down;
        bit    clr;
        int    exp_val;
        bit    exp_wrap;
        string name;
    } vec_t;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic release_keys();
        key_up    = 1'b1;
        key_down  = 1'b1;
        key_clear = 1'b1;
    endtask

    // Clean press of the selected keys with exact-latency and hold checks.
    task automatic press(input bit u, input bit d, input bit c,
                         input int exp_v, input bit exp_w, input string nm);
        logic [7:0] old_bcd;
        logic [7:0] new_bcd;
        old_bcd = to_bcd(model_val);
        new_bcd = to_bcd(exp_v);
        key_up    = u ? 1'b0 : 1'b1;
        key_down  = d ? 1'b0 : 1'b1;
        key_clear = c ? 1'b0 : 1'b1;
        repeat (DB + 3) tick();
        chk({nm, "_early_bcd"}, bcd_out, old_bcd);
        chk({nm, "_early_wrap"}, {7'd0, wrap}, 8'd0);
        tick();
        chk({nm, "_bcd"}, bcd_out, new_bcd);
        chk({nm, "_wrap"}, {7'd0, wrap}, {7'd0, exp_w});
        tick();
        chk({nm, "_wrap_end"}, {7'd0, wrap}, 8'd0);
        repeat (3) tick();
        chk({nm, "_held"}, bcd_out, new_bcd);
        release_keys();
        repeat (DB + 6) tick();
        chk({nm, "_released"}, bcd_out, new_bcd);
        $display("txn %s: keys u=%0d d=%0d c=%0d -> bcd=%h wrap_exp=%0d", nm, u, d, c, bcd_out, exp_w);
        model_val = exp_v;
    endtask

    // Reference rules on a plain integer value.
    task automatic model_step(input bit u, input bit d, input bit c,
                              output int nv, output bit w);
        nv = model_val;
        w  = 1'b0;
        if (c) begin
            nv = 0;
        end else if (u && !d) begin
            w  = (model_val == 99);
            nv = (model_val + 1) % 100;
        end else if (d && !u) begin
            w  = (model_val == 0);
            nv = (model_val + 99) % 100;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int nv;
        bit w;

        vecs[0] = '{0, 0, 1,  0, 0, "tbl_clear"};
        vecs[1] = '{0, 1, 0, 99, 1, "tbl_down_wrap"};
        vecs[2] = '{1, 0, 0,  0, 1, "tbl_up_wrap"};
        vecs[3] = '{1, 0, 0,  1, 0, "tbl_up"};
        vecs[4] = '{1, 1, 0,  1, 0, "tbl_up_down"};
        vecs[5] = '{0, 1, 0,  0, 0, "tbl_down"};
        vecs[6] = '{1, 0, 1,  0, 0, "tbl_clear_up"};

        // Reset
        repeat (3) tick();
        chk("reset_bcd", bcd_out, 8'h00);
        chk("reset_wrap", {7'd0, wrap}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_bcd", bcd_out, 8'h00);
            chk("idle_wrap", {7'd0, wrap}, 8'd0);
        end
        $display("txn reset_idle: bcd=%h", bcd_out);

        // Ten clean up presses
        for (int i = 1; i <= 10; i++) press(1, 0, 0, i, 0, "up_clean");
        chk("ten_ups", bcd_out, 8'h10);

        // Bounce shorter than the window
        for (int i = 0; i < 40; i++) begin
            key_up = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk("bounce_bcd", bcd_out, 8'h10);
        end
        key_up = 1'b1;
        repeat (10) tick();
        chk("bounce_after", bcd_out, 8'h10);
        $display("txn bounce: bcd=%h", bcd_out);
        press(1, 0, 0, 11, 0, "up_after_bounce");

        // Preload 99, then wrap both ways
        for (int i = 12; i <= 99; i++) press(1, 0, 0, i, 0, "preload");
        press(1, 0, 0, 0, 1, "wrap_up");
        press(0, 1, 0, 99, 1, "wrap_down");

        // Digit carry and borrow
        press(0, 0, 1, 0, 0, "clear");
        for (int i = 1; i <= 19; i++) press(1, 0, 0, i, 0, "to19");
        press(1, 0, 0, 20, 0, "carry");
        press(0, 1, 0, 19, 0, "borrow");

        // Table vectors
        for (int i = 0; i < 7; i++)
            press(vecs[i].up, vecs[i].down, vecs[i].clr, vecs[i].exp_val, vecs[i].exp_wrap, vecs[i].name);

        // Clear together with up at 42
        for (int i = 1; i <= 42; i++) press(1, 0, 0, i, 0, "to42");
        press(1, 0, 1, 0, 0, "clear_with_up");

        // Randomized operations against the model
        for (int n = 0; n < 120; n++) begin
            int r;
            bit u;
            bit d;
            bit c;
            r = int'($urandom_range(0, 9));
            u = 0; d = 0; c = 0;
            if (r == 0) begin
                c = 1; u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
            end else if (r == 1) begin
                u = 1; d = 1;
            end else if (r < 6) begin
                u = 1;
            end else begin
                d = 1;
            end
            model_step(u, d, c, nv, w);
            press(u, d, c, nv, w, "rand");
        end

        // Reset in the middle of a debounce with the key still held
        press(0, 0, 1, 0, 0, "pre_rst_clear");
        press(1, 0, 0, 1, 0, "pre_rst_up");
        press(1, 0, 0, 2, 0, "pre_rst_up");
        key_up = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd", bcd_out, 8'h00);
        chk("midrst_wrap", {7'd0, wrap}, 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_val = 0;
        repeat (DB + 3) tick();
        chk("midrst_early", bcd_out, 8'h00);
        tick();
        chk("midrst_press", bcd_out, 8'h01);
        repeat (5) tick();
        chk("midrst_held", bcd_out, 8'h01);
        key_up = 1'b1;
        repeat (DB + 6) tick();
        chk("midrst_released", bcd_out, 8'h01);
        $display("txn reset_mid_debounce: bcd=%h", bcd_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
